// File: rtl/rot_seq_pkg.sv
// Shared types for the rotate-pattern sequencer: FSM state encoding and
// requester/owner identifiers.
package rot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone requester always wins, and on
// contention the requester that was not granted last wins.
module rr_arb2
    import rot_seq_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = OWN_A;
        if (req_a && req_b) begin
            winner = (last_grant == OWN_A) ? OWN_B : OWN_A;
        end else if (req_b) begin
            winner = OWN_B;
        end
    end

endmodule

// File: rtl/rot_seq_ctrl.sv
// Two-requester load/rotate sequencer: grants a requester, loads its pattern,
// rotates it toward the MSB a requested number of steps at a divided rate.
module rot_seq_ctrl
    import rot_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic [CNT_W-1:0] steps_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [CNT_W-1:0] steps_b,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] pattern,
    output logic             owner,
    output logic             busy,
    output logic             done
);

    state_e             state_q;
    logic [WIDTH-1:0]   pattern_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [DIV_W-1:0]   tick_q;
    logic [DIV_W-1:0]   div_q;
    logic               owner_q;
    logic               last_grant_q;
    logic               gnt_a_q;
    logic               gnt_b_q;
    logic               done_q;
    logic               busy_q;

    logic               arb_valid;
    logic               arb_winner;
    logic [WIDTH-1:0]   win_data;
    logic [CNT_W-1:0]   win_steps;
    logic [WIDTH-1:0]   pattern_rot;

    rr_arb2 u_arb (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign win_data    = (arb_winner == OWN_B) ? data_b  : data_a;
    assign win_steps   = (arb_winner == OWN_B) ? steps_b : steps_a;
    assign pattern_rot = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};

    // done/busy/gnt are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pattern_q    <= '0;
            remaining_q  <= '0;
            tick_q       <= '0;
            div_q        <= '0;
            owner_q      <= OWN_A;
            last_grant_q <= OWN_B;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        pattern_q    <= win_data;
                        remaining_q  <= win_steps;
                        tick_q       <= div;
                        div_q        <= div;
                        owner_q      <= arb_winner;
                        last_grant_q <= arb_winner;
                        gnt_a_q      <= (arb_winner == OWN_A);
                        gnt_b_q      <= (arb_winner == OWN_B);
                        busy_q       <= 1'b1;
                        if (win_steps != '0) begin
                            state_q <= ROTATE;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ROTATE: begin
                    // Abort takes priority over a rotation due on the same edge.
                    if (abort) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (tick_q != '0) begin
                        tick_q <= tick_q - DIV_W'(1);
                    end else begin
                        pattern_q   <= pattern_rot;
                        remaining_q <= remaining_q - CNT_W'(1);
                        tick_q      <= div_q;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign pattern = pattern_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Self-checking bench for rot_seq_ctrl: directed scenarios plus randomized
// runs checked against a cycle-indexed model of the expected run timeline.
module tb_rot_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [3:0] data_a = '0, data_b = '0;
    logic [3:0] steps_a = '0, steps_b = '0;
    logic [7:0] div = '0;
    logic       abort = 1'b0;
    logic       gnt_a, gnt_b, owner, busy, done;
    logic [3:0] pattern;

    int n_pass = 0;
    int n_total = 0;
    logic last_gnt_m = 1'b1;

    rot_seq_ctrl #(.WIDTH(4), .CNT_W(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .steps_a(steps_a),
        .req_b(req_b), .data_b(data_b), .steps_b(steps_b),
        .div(div), .abort(abort),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .pattern(pattern),
        .owner(owner), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pattern after k rotations toward the MSB with wrap.
    function automatic logic [3:0] rotl(input logic [3:0] d, input int k);
        int v;
        int kk;
        kk = k % 4;
        v  = int'(d);
        v  = ((v << kk) | (v >> (4 - kk))) & 15;
        return v[3:0];
    endfunction

    // One run: request, wait for grant, then check every cycle until the
    // cycle after done. Cycle j is the cycle following edge E0+j.
    task automatic do_run(input logic who, input logic [3:0] d, input logic [3:0] s,
                          input logic [7:0] dv, input int abort_at, input string tag);
        int got, wrong, e, cap, rots;
        logic [3:0] exp_p;
        if (who == 1'b0) begin data_a = d; steps_a = s; req_a = 1'b1; end
        else             begin data_b = d; steps_b = s; req_b = 1'b1; end
        div = dv;
        got = 0;
        wrong = 0;
        for (int w = 0; w < 80 && got == 0; w++) begin
            @(posedge clk); #1;
            if ((who ? gnt_b : gnt_a) === 1'b1) got = 1;
            else if ((who ? gnt_a : gnt_b) === 1'b1) wrong = 1;
        end
        n_total++;
        if (got == 0) begin
            $display("FAIL %s grant: gnt never seen, required within 80 cycles", tag);
            req_a = 1'b0; req_b = 1'b0;
            return;
        end
        n_pass++;
        n_total++;
        if (wrong != 0 || (who ? gnt_a : gnt_b) !== 1'b0)
            $display("FAIL %s arbitration: other requester granted, required winner %0d", tag, who);
        else n_pass++;
        n_total++;
        if (owner !== who) $display("FAIL %s owner: got %0d, required %0d", tag, owner, who);
        else n_pass++;
        last_gnt_m = who;
        // Handshake release, then disturb div/steps/data to show they are not re-sampled.
        if (who == 1'b0) begin req_a = 1'b0; data_a = 4'($urandom); steps_a = 4'($urandom); end
        else             begin req_b = 1'b0; data_b = 4'($urandom); steps_b = 4'($urandom); end
        div = 8'($urandom);
        cap = (abort_at >= 0) ? abort_at / (int'(dv) + 1) : int'(s);
        e   = (abort_at >= 0) ? abort_at + 1 : int'(s) * (int'(dv) + 1);
        for (int j = 0; j <= e + 1; j++) begin
            rots = j / (int'(dv) + 1);
            if (rots > cap) rots = cap;
            exp_p = rotl(d, rots);
            n_total++;
            if (pattern !== exp_p)
                $display("FAIL %s pattern c%0d: got %b, required %b", tag, j, pattern, exp_p);
            else n_pass++;
            n_total++;
            if (done !== (j == e))
                $display("FAIL %s done c%0d: got %b, required %b", tag, j, done, (j == e));
            else n_pass++;
            n_total++;
            if (busy !== (j <= e))
                $display("FAIL %s busy c%0d: got %b, required %b", tag, j, busy, (j <= e));
            else n_pass++;
            abort = (j == abort_at);
            if (j <= e) begin @(posedge clk); #1; end
        end
        abort = 1'b0;
    endtask

    task automatic apply_reset();
        req_a = 1'b0; req_b = 1'b0; abort = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        last_gnt_m = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_total++;
        if (pattern !== 4'b0000) $display("FAIL reset pattern: got %b, required 0000", pattern);
        else n_pass++;
        n_total++;
        if ({gnt_a, gnt_b, busy, done, owner} !== 5'b0)
            $display("FAIL reset outputs: gnt_a/gnt_b/busy/done/owner got %b, required 00000",
                     {gnt_a, gnt_b, busy, done, owner});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_run(1'b0, 4'b0001, 4'd3, 8'd0, -1, "basic");
    endtask

    task automatic test_rate();
        do_run(1'b1, 4'b1001, 4'd2, 8'd3, -1, "rate");
        do_run(1'b0, 4'b0110, 4'd4, 8'd1, -1, "wrap");
    endtask

    task automatic test_steps_zero();
        do_run(1'b0, 4'b1010, 4'd0, 8'd5, -1, "steps0");
    endtask

    task automatic test_abort();
        do_run(1'b1, 4'b0001, 4'd15, 8'd0, 2, "abort");
    endtask

    // Both requesters held from reset: A first, B granted two edges after A's done.
    task automatic test_back_to_back();
        int da, gb, db, ga;
        apply_reset();
        data_a = 4'b0011; steps_a = 4'd2;
        data_b = 4'b0101; steps_b = 4'd3;
        div = 8'd0;
        req_a = 1'b1; req_b = 1'b1;
        ga = -1; da = -1; gb = -1; db = -1;
        for (int j = 0; j <= 20; j++) begin
            @(posedge clk); #1;
            if (ga < 0) begin
                if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
                    ga = j;
                    n_total++;
                    if (gnt_a !== 1'b1 || gnt_b !== 1'b0)
                        $display("FAIL contention first: gnt_a/gnt_b got %b%b, required 10", gnt_a, gnt_b);
                    else n_pass++;
                    req_a = 1'b0;
                end
            end else begin
                if (gnt_b === 1'b1 && gb < 0) begin
                    gb = j - ga;
                    req_b = 1'b0;
                    n_total++;
                    if (pattern !== 4'b0101 || owner !== 1'b1)
                        $display("FAIL contention load B: pattern/owner got %b/%b, required 0101/1", pattern, owner);
                    else n_pass++;
                end
                if (done === 1'b1) begin
                    if (da < 0) da = j - ga;
                    else if (db < 0) db = j - ga;
                end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        last_gnt_m = 1'b1;
        n_total++;
        if (da !== 2) $display("FAIL contention A done: got cycle %0d, required 2", da);
        else n_pass++;
        n_total++;
        if (gb !== 4) $display("FAIL contention B grant: got cycle %0d, required 4", gb);
        else n_pass++;
        n_total++;
        if (db !== 7) $display("FAIL contention B done: got cycle %0d, required 7", db);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int dcount, bcount;
        data_a = 4'b0001; steps_a = 4'd15; div = 8'd0; req_a = 1'b1; req_b = 1'b0;
        @(posedge clk); #1;
        req_a = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if (pattern !== 4'b0000) $display("FAIL async reset pattern: got %b, required 0000", pattern);
        else n_pass++;
        n_total++;
        if ({gnt_a, gnt_b, busy, done, owner} !== 5'b0)
            $display("FAIL async reset outputs: got %b, required 00000", {gnt_a, gnt_b, busy, done, owner});
        else n_pass++;
        #2;
        rst = 1'b0;
        last_gnt_m = 1'b1;
        dcount = 0; bcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
            if (busy === 1'b1) bcount++;
        end
        n_total++;
        if (dcount != 0 || bcount != 0)
            $display("FAIL async reset aftermath: done/busy cycles got %0d/%0d, required 0/0", dcount, bcount);
        else n_pass++;
        do_run(1'b1, 4'b1100, 4'd2, 8'd1, -1, "post_reset_b");
    endtask

    task automatic test_random();
        logic       both, w, l;
        logic [3:0] d, s, dl, sl;
        logic [7:0] dv, dvl;
        int         ab;
        for (int it = 0; it < 25; it++) begin
            both = ($urandom_range(0, 2) == 0);
            d  = 4'($urandom); s  = 4'($urandom_range(0, 15)); dv  = 8'($urandom_range(0, 3));
            dl = 4'($urandom); sl = 4'($urandom_range(0, 15)); dvl = 8'($urandom_range(0, 3));
            ab = (s != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(s) * (int'(dv) + 1) - 1)) : -1;
            if (both) begin
                w = ~last_gnt_m;
                l = ~w;
                if (l == 1'b0) begin data_a = dl; steps_a = sl; req_a = 1'b1; end
                else           begin data_b = dl; steps_b = sl; req_b = 1'b1; end
                do_run(w, d, s, dv, ab, "rand_win");
                do_run(l, dl, sl, dvl, -1, "rand_lose");
            end else begin
                w = 1'($urandom_range(0, 1));
                do_run(w, d, s, dv, ab, "rand_one");
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_rate();
        test_steps_zero();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rot_seq_ctrl.md
# rot_seq_ctrl

Sequencer and two-requester arbiter for the team's 4-bit load/rotate pattern register. Each requester submits a parallel pattern and a step count. The block grants one requester at a time (round-robin), loads the pattern, rotates it the requested number of steps at a programmable rate, then signals completion. It owns the pattern register and drives the display-gating logic downstream.

## Interface
- WIDTH, 4: pattern register width.
- CNT_W, 4: step-count width; max rotation run is 2^CNT_W-1 steps.
- DIV_W, 8: rate-divider width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A request; held high until gnt_a is seen.
- data_a  in  WIDTH  A pattern; stable while req_a is high.
- steps_a  in  CNT_W  A rotation count; stable while req_a is high.
- req_b / data_b / steps_b  in  1 / WIDTH / CNT_W  same for requester B.
- div  in  DIV_W  step period minus one; sampled at grant.
- abort  in  1  terminates an active rotation run.
- gnt_a, gnt_b  out  1  one-cycle grant pulses.
- pattern  out  WIDTH  current register contents.
- owner  out  1  0=A, 1=B; requester of the current or most recent run.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, ROTATE and DONE.
- IDLE: at a clock edge where any req is high, the block grants one requester.
  - Single request: that requester wins.
  - Both requesting: the requester not granted last wins.
  - On the grant edge: pattern <= winner data; remaining <= winner steps; tick <= div; owner <= winner; last_grant <= winner.
  - Next state is ROTATE if steps != 0, otherwise DONE.
- Grant pulse: gnt_x is a registered signal, high for exactly the one cycle after the grant edge.
- ROTATE: each edge with tick != 0 decrements tick. An edge with tick == 0:
  - rotates pattern toward the MSB with wrap: pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
  - decrements remaining and reloads tick from the captured div;
  - moves to DONE if remaining becomes 0.
- abort high in ROTATE moves to DONE at the next edge with no rotation on that edge. pattern holds its value. abort is ignored in IDLE and DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally. Requests are not sampled in DONE.
- pattern holds its value in IDLE and DONE.
- div and steps changes after the grant have no effect on the run in progress.

## Timing
- Reset values: pattern=0, gnt_a=gnt_b=0, busy=0, done=0, owner=0, state=IDLE, last_grant=B. A therefore wins the first contested arbitration.
- Latency: the grant edge is E0.
  - Rotation k (1..steps) occurs at edge E0 + k·(div+1).
  - done is high in the cycle after edge E0 + steps·(div+1).
  - busy falls one cycle after done.
- steps=0: done is high in the cycle after E0, coinciding with the gnt pulse. Back-to-back runs:
  - Earliest next grant edge is the edge ending the first IDLE cycle.
  - Minimum grant-to-grant spacing is steps·(div+1)+2 edges.
- Handshake: a requester deasserts req on the edge after it observes gnt. A req still high at the end of its gnt cycle is never re-granted, because the FSM is in ROTATE or DONE at that edge.
- rst asserted mid-run: all outputs return to reset values immediately (asynchronous). The in-flight run is lost and no done pulse is issued.
- Wrap-around: after WIDTH rotations, pattern equals the loaded value.

## Structure
- Package rot_seq_pkg holds:
  - the state enum (IDLE, ROTATE, DONE);
  - owner encoding constants OWN_A=0, OWN_B=1.
- One sub-module, rr_arb2, implements the two-input round-robin arbiter.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: valid, winner.
  - Purely combinational.
- The FSM, counters and pattern register live in rot_seq_ctrl.

## Test plan
- Reset, then req_a with data_a=4'b0001, steps_a=3, div=0 → gnt_a one cycle after the grant edge; pattern 0001→0010→0100→1000 on consecutive edges; done pulse; owner=0.
- Contention: req_a and req_b both held high from reset → A granted first, then B; B's pattern is loaded and its done appears after A's done plus one IDLE cycle.
- Rate: data=4'b1001, steps=2, div=3 → rotations at E0+4 and E0+8 (pattern 0011, then 0110); done is high in the cycle after E0+8.
- Boundary: steps=0, data=4'b1010 → pattern=1010, gnt and done in the same cycle, no rotation, busy high for exactly one cycle.
- abort during ROTATE: steps=15, div=0, abort asserted after 2 rotations (pattern 0100 from 0001) → DONE at the next edge, pattern holds 0100.
- Async rst asserted mid-run → pattern=0, busy=0, no done; a subsequent req_b with req_a low is granted B.
